// File: rtl/program_sequencer_stack_if.sv
// Decoder <-> program sequencer bus: control strobes, jump operands, address and stack status.
// slave is the sequencer side; master is the decoder/observer side.
interface program_sequencer_stack_if #(
  parameter int unsigned PC_WIDTH     = 8,
  parameter int unsigned OFFSET_WIDTH = 4,
  parameter int unsigned STACK_DEPTH  = 4
);
  localparam int unsigned DW = $clog2(STACK_DEPTH + 1);

  logic                    jump;
  logic                    cond_jump;
  logic                    dont_jmp;
  logic                    call;
  logic                    ret;
  logic [PC_WIDTH-1:0]     jump_addr;
  logic [OFFSET_WIDTH-1:0] rel_offset;
  logic [PC_WIDTH-1:0]     pm_address;
  logic [PC_WIDTH-1:0]     pc;
  logic [DW-1:0]           stack_depth;
  logic                    stack_ovf;
  logic                    stack_unf;

  modport master (
    output jump, cond_jump, dont_jmp, call, ret, jump_addr, rel_offset,
    input  pm_address, pc, stack_depth, stack_ovf, stack_unf
  );

  modport slave (
    input  jump, cond_jump, dont_jmp, call, ret, jump_addr, rel_offset,
    output pm_address, pc, stack_depth, stack_ovf, stack_unf
  );
endinterface

// File: rtl/program_sequencer_stack.sv
// Program sequencer: next-address generation with jump, conditional relative jump and an optional
// hardware return-address stack (enabled by defining CALL_STACK_EN).
module program_sequencer_stack #(
  parameter int unsigned PC_WIDTH     = 8,
  parameter int unsigned OFFSET_WIDTH = 4,
  parameter int unsigned STACK_DEPTH  = 4
) (
  input logic                           clk,
  input logic                           reset,
  program_sequencer_stack_if.slave      bus
);
  localparam int unsigned DW = $clog2(STACK_DEPTH + 1);

  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pm_d;
  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] rel_ext;

  assign pc_inc  = pc_q + PC_WIDTH'(1);
  assign rel_ext = {{(PC_WIDTH - OFFSET_WIDTH){bus.rel_offset[OFFSET_WIDTH-1]}}, bus.rel_offset};

`ifdef CALL_STACK_EN
  logic [PC_WIDTH-1:0] stack_q [STACK_DEPTH];
  logic [DW-1:0]       depth_q, depth_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;
  logic                push;
  logic [PC_WIDTH-1:0] top;

  always_comb begin
    top = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (DW'(i) == depth_q - DW'(1)) top = stack_q[i];
    end
  end
`endif

  always_comb begin
    pm_d = pc_inc;
`ifdef CALL_STACK_EN
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push    = 1'b0;
`endif
    if (reset) begin
      pm_d = '0;
`ifdef CALL_STACK_EN
      depth_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
`endif
    end else if (bus.ret) begin
`ifdef CALL_STACK_EN
      // Underflowing return degrades to a plain increment.
      if (depth_q == '0) begin
        unf_d = 1'b1;
      end else begin
        pm_d    = top;
        depth_d = depth_q - DW'(1);
      end
`else
      pm_d = pc_inc;
`endif
    end else if (bus.call) begin
      pm_d = bus.jump_addr;
`ifdef CALL_STACK_EN
      if (depth_q == DW'(STACK_DEPTH)) begin
        ovf_d = 1'b1;
      end else begin
        push    = 1'b1;
        depth_d = depth_q + DW'(1);
      end
`endif
    end else if (bus.jump) begin
      pm_d = bus.jump_addr;
    end else if (bus.cond_jump && !bus.dont_jmp) begin
      pm_d = pc_q + rel_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) pc_q <= '0;
    else       pc_q <= pm_d;
  end

`ifdef CALL_STACK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack contents are don't-care after reset; only depth qualifies them.
  always_ff @(posedge clk) begin
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (push && DW'(i) == depth_q) stack_q[i] <= pc_inc;
    end
  end

  assign bus.stack_depth = depth_q;
  assign bus.stack_ovf   = ovf_q;
  assign bus.stack_unf   = unf_q;
`else
  assign bus.stack_depth = '0;
  assign bus.stack_ovf   = 1'b0;
  assign bus.stack_unf   = 1'b0;
`endif

  assign bus.pm_address = pm_d;
  assign bus.pc         = pc_q;
endmodule

// File: tb/tb_program_sequencer_stack.sv
// Table-driven bench for program_sequencer_stack; expectations adapt to CALL_STACK_EN.
module tb_program_sequencer_stack;
`ifdef CALL_STACK_EN
  localparam bit En = 1'b1;
`else
  localparam bit En = 1'b0;
`endif

  typedef struct {
    logic       rst, jmp, cj, dj, cl, rt;
    logic [7:0] addr;
    logic [3:0] off;
    logic [7:0] exp_pm;
    logic [2:0] exp_d;
    logic       exp_o, exp_u;
  } vec_t;

  typedef struct {
    logic [7:0] pc;
    logic [2:0] d;
    logic       o, u;
  } sb_t;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vecs[$];
  sb_t  sb[$];

  always #5 clk = ~clk;

  program_sequencer_stack_if #(.PC_WIDTH(8), .OFFSET_WIDTH(4), .STACK_DEPTH(4)) bus ();

  program_sequencer_stack #(.PC_WIDTH(8), .OFFSET_WIDTH(4), .STACK_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // pm_en/d/ov/un describe the stack-enabled build; without the stack depth and flags read 0.
  function automatic vec_t mk(logic rst, logic j, logic cj, logic dj, logic cl, logic rt,
                              logic [7:0] a, logic [3:0] o, logic [7:0] pm_en,
                              logic [7:0] pm_dis, int d, logic ov, logic un);
    vec_t v;
    v.rst = rst; v.jmp = j; v.cj = cj; v.dj = dj; v.cl = cl; v.rt = rt;
    v.addr = a; v.off = o;
    v.exp_pm = En ? pm_en : pm_dis;
    v.exp_d  = En ? 3'(d) : 3'd0;
    v.exp_o  = En & ov;
    v.exp_u  = En & un;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp, int idx);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    sb_t e;
    @(negedge clk);
    reset          = v.rst;
    bus.jump       = v.jmp;
    bus.cond_jump  = v.cj;
    bus.dont_jmp   = v.dj;
    bus.call       = v.cl;
    bus.ret        = v.rt;
    bus.jump_addr  = v.addr;
    bus.rel_offset = v.off;
    #1;
    chk("pm_address", 32'(bus.pm_address), 32'(v.exp_pm), idx);
    sb.push_back('{pc: v.exp_pm, d: v.exp_d, o: v.exp_o, u: v.exp_u});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard vec %0d: got empty queue expected an entry", idx);
    end else begin
      e = sb.pop_front();
      chk("pc", 32'(bus.pc), 32'(e.pc), idx);
      chk("stack_depth", 32'(bus.stack_depth), 32'(e.d), idx);
      chk("stack_ovf", 32'(bus.stack_ovf), 32'(e.o), idx);
      chk("stack_unf", 32'(bus.stack_unf), 32'(e.u), idx);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.jump = 1'b0; bus.cond_jump = 1'b0; bus.dont_jmp = 1'b0;
    bus.call = 1'b0; bus.ret = 1'b0; bus.jump_addr = '0; bus.rel_offset = '0;

    //                rst j cj dj cl rt addr   off    pm_en  pm_dis d ov un
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 8'h00, 4'h0, 8'h00, 8'h00, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00, 4'h0, 8'h01, 8'h01, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00, 4'h0, 8'h02, 8'h02, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 8'h10, 4'h0, 8'h10, 8'h10, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 8'hA0, 4'h0, 8'hA0, 8'hA0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 8'h20, 4'h0, 8'h20, 8'h20, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 8'h00, 4'hC, 8'h1C, 8'h1C, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 8'h20, 4'h0, 8'h20, 8'h20, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 8'h00, 4'hC, 8'h21, 8'h21, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 8'hFF, 4'h0, 8'hFF, 8'hFF, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00, 4'h0, 8'h00, 8'h00, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 8'h00, 4'hF, 8'hFF, 8'hFF, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 8'h05, 4'h0, 8'h05, 8'h05, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 8'h30, 4'h0, 8'h30, 8'h30, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 8'h35, 4'h0, 8'h35, 8'h35, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 8'h40, 4'h0, 8'h40, 8'h40, 2, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 8'h45, 4'h0, 8'h45, 8'h45, 2, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 8'h50, 4'h0, 8'h50, 8'h50, 3, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 8'h55, 4'h0, 8'h55, 8'h55, 3, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 8'h60, 4'h0, 8'h60, 8'h60, 4, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 8'h00, 4'h0, 8'h56, 8'h61, 3, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 8'h00, 4'h0, 8'h46, 8'h62, 2, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 8'h00, 4'h0, 8'h36, 8'h63, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 8'h00, 4'h0, 8'h06, 8'h64, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 8'h70, 4'h0, 8'h70, 8'h70, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 8'h71, 4'h0, 8'h71, 8'h71, 2, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 8'h72, 4'h0, 8'h72, 8'h72, 3, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 8'h73, 4'h0, 8'h73, 8'h73, 4, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 8'h80, 4'h0, 8'h80, 8'h80, 4, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 8'h00, 4'h0, 8'h73, 8'h81, 3, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 8'h00, 4'h0, 8'h72, 8'h82, 2, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 8'h83, 4'h0, 8'h71, 8'h83, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 8'h00, 4'h0, 8'h07, 8'h84, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 8'h00, 4'h0, 8'h08, 8'h85, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00, 4'h0, 8'h09, 8'h86, 0, 1, 1));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 8'h90, 4'h0, 8'h00, 8'h00, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00, 4'h0, 8'h01, 8'h01, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 8'h40, 4'h0, 8'h40, 8'h40, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 8'h00, 4'h0, 8'h00, 8'h00, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00, 4'h0, 8'h01, 8'h01, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Hand sequence: increment across the top of the address space.
    apply(mk(0, 1, 0, 0, 0, 0, 8'hFE, 4'h0, 8'hFE, 8'hFE, 0, 0, 0), 100);
    apply(mk(0, 0, 0, 0, 0, 0, 8'h00, 4'h0, 8'hFF, 8'hFF, 0, 0, 0), 101);
    apply(mk(0, 0, 0, 0, 0, 0, 8'h00, 4'h0, 8'h00, 8'h00, 0, 0, 0), 102);

    // Hand sequence: jump outranks cond_jump; negative offset from a mid address.
    apply(mk(0, 1, 1, 0, 0, 0, 8'h44, 4'h8, 8'h44, 8'h44, 0, 0, 0), 103);
    apply(mk(0, 0, 1, 0, 0, 0, 8'h00, 4'h8, 8'h3C, 8'h3C, 0, 0, 0), 104);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
